// File: rtl/uart6551_pkg.sv
// uart6551_pkg: shared types for the 6551 receive-side read scheduler.
package uart6551_pkg;
  typedef enum logic [1:0] {IDLE, READ, GAP, DELIVER} state_t;
  typedef enum logic {G_CPU, G_DMA} grant_t;
  typedef struct packed {
    logic       brk;
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_word_t;
endpackage

// File: rtl/uart6551_rx_tmo.sv
// uart6551_rx_tmo: idle-with-data timeout counter, saturating at TMO_TICKS.
module uart6551_rx_tmo #(
  parameter int TMO_TICKS = 640
) (
  input  logic clk,
  input  logic rst,
  input  logic baud16x_ce,
  input  logic rx_empty,
  input  logic clr,
  output logic tmo
);
  localparam int W = $clog2(TMO_TICKS + 1);
  localparam logic [W-1:0] MAX = W'(TMO_TICKS);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clr || rx_empty) ? '0 : (baud16x_ce && cnt != MAX) ? cnt + 1'b1 : cnt;
  assign tmo = cnt == MAX;
endmodule

// File: rtl/uart6551_rx_sched.sv
// uart6551_rx_sched: shares the receiver FIFO read port between CPU and DMA with spaced read cycles.
module uart6551_rx_sched
  import uart6551_pkg::*;
#(
  parameter int THRESH    = 8,
  parameter int TMO_TICKS = 640
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud16x_ce,
  output logic        rx_cyc,
  output logic        rx_cs,
  output logic        rx_wr,
  input  logic        rx_ack,
  input  logic [7:0]  rx_dout,
  input  logic        rx_break,
  input  logic        rx_perr,
  input  logic        rx_ferr,
  input  logic        rx_empty,
  input  logic [3:0]  rx_qcnt,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [10:0] cpu_dat,
  output logic        cpu_nodata,
  input  logic        dma_en,
  output logic        dma_valid,
  input  logic        dma_ready,
  output logic [10:0] dma_dat,
  output logic        irq
);
  localparam logic [3:0] TH = 4'(THRESH);
  state_t   state;
  grant_t   grant, last_grant;
  rx_word_t word;
  logic burst, tmo, lvl, burst_p, cpu_win;
  assign lvl     = rx_qcnt >= TH;
  assign burst_p = dma_en && (burst || lvl || tmo);
  assign cpu_win = cpu_req && (!burst_p || last_grant == G_DMA);
  assign rx_cs   = rx_cyc;
  assign rx_wr   = 1'b0;
  uart6551_rx_tmo #(.TMO_TICKS(TMO_TICKS)) u_tmo (
    .clk        (clk),
    .rst        (rst),
    .baud16x_ce (baud16x_ce && state == IDLE),
    .rx_empty   (rx_empty),
    .clr        (state == READ),
    .tmo        (tmo)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state      <= IDLE;
      grant      <= G_DMA;
      last_grant <= G_DMA;
      burst      <= 1'b0;
      word       <= '0;
      rx_cyc     <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_nodata <= 1'b0;
      cpu_dat    <= '0;
      dma_valid  <= 1'b0;
      dma_dat    <= '0;
      irq        <= 1'b0;
    end else begin
      irq   <= !dma_en && (lvl || tmo);
      burst <= burst && dma_en;
      case (state)
        IDLE: begin
          burst <= burst_p;
          if (cpu_win && rx_empty) begin
            cpu_ack    <= 1'b1;
            cpu_nodata <= 1'b1;
            cpu_dat    <= '0;
            grant      <= G_CPU;
            last_grant <= G_CPU;
            state      <= DELIVER;
          end else if (cpu_win || (burst_p && !rx_empty)) begin
            grant      <= cpu_win ? G_CPU : G_DMA;
            last_grant <= cpu_win ? G_CPU : G_DMA;
            rx_cyc     <= 1'b1;
            state      <= READ;
          end
        end
        READ: begin
          rx_cyc <= 1'b0;
          word   <= {rx_break, rx_perr, rx_ferr, rx_dout};
          state  <= GAP;
        end
        GAP: begin
          if (rx_empty) burst <= 1'b0;
          if (grant == G_CPU) begin
            cpu_ack    <= 1'b1;
            cpu_nodata <= 1'b0;
            cpu_dat    <= word;
          end else begin
            dma_valid <= 1'b1;
            dma_dat   <= word;
          end
          state <= DELIVER;
        end
        DELIVER: begin
          if (grant == G_CPU) begin
            cpu_ack    <= 1'b0;
            cpu_nodata <= 1'b0;
            state      <= IDLE;
          end else if (dma_ready) begin
            dma_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_uart6551_rx_sched.sv
// tb_uart6551_rx_sched: scoreboard bench with a behavioural receiver FIFO.
module tb_uart6551_rx_sched;
  logic clk = 0, rst = 0, baud16x_ce = 0, cpu_req = 0, dma_en = 0, dma_ready = 0;
  logic rx_cyc, rx_cs, rx_wr, rx_ack, cpu_ack, cpu_nodata, dma_valid, irq;
  logic rx_break = 0, rx_perr = 0, rx_ferr = 0, rx_empty = 1;
  logic [7:0]  rx_dout = 0;
  logic [3:0]  rx_qcnt = 0;
  logic [10:0] cpu_dat, dma_dat;
  int checks = 0, errors = 0, cyc = 0, rdcnt = 0, last_rd = -10, ticks = 0, ndeliv = 0;
  logic [10:0] fifo[$], exp_q[$];
  logic gseq[$];
  logic push_en = 0, ack_d = 0;
  logic [10:0] push_val = 0;
  logic [1:0] bc = 0;

  assign rx_ack = rx_cyc & rx_cs;

  uart6551_rx_sched dut (
    .clk(clk), .rst(rst), .baud16x_ce(baud16x_ce),
    .rx_cyc(rx_cyc), .rx_cs(rx_cs), .rx_wr(rx_wr), .rx_ack(rx_ack),
    .rx_dout(rx_dout), .rx_break(rx_break), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_empty(rx_empty), .rx_qcnt(rx_qcnt),
    .cpu_req(cpu_req), .cpu_ack(cpu_ack), .cpu_dat(cpu_dat), .cpu_nodata(cpu_nodata),
    .dma_en(dma_en), .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_dat(dma_dat),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic deliver(logic [10:0] d, logic g);
    if (exp_q.size() == 0) chk("sb_under", 0, 1);
    else chk(g ? "dma_dat" : "cpu_dat", d, exp_q.pop_front());
    gseq.push_back(g);
    ndeliv++;
  endtask

  // Receiver model: pops on the rising edge of ack, outputs settle after the edge.
  always @(posedge clk) begin
    if (rx_ack && !rx_wr && !ack_d && fifo.size() > 0) void'(fifo.pop_front());
    if (push_en) fifo.push_back(push_val);
    ack_d <= rx_ack;
    rx_empty <= fifo.size() == 0;
    rx_qcnt <= fifo.size() > 15 ? 4'd15 : 4'(fifo.size());
    {rx_break, rx_perr, rx_ferr, rx_dout} <= fifo.size() > 0 ? fifo[0] : 11'h0;
    ticks <= (rx_empty || rx_cyc) ? 0 : (baud16x_ce && ticks < 640) ? ticks + 1 : ticks;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    bc <= bc + 1'b1;
    baud16x_ce <= bc == 2'd0;
  end

  always @(negedge clk) if (rst) begin
    if (rx_cyc) begin
      chk("rd_space", (cyc - last_rd) >= 3, 1);
      chk("rd_cs_wr", {rx_cs, rx_wr}, 2'b10);
      last_rd = cyc;
      rdcnt++;
    end
    if (cpu_ack && !cpu_nodata) deliver(cpu_dat, 1'b0);
    if (dma_valid && dma_ready) deliver(dma_dat, 1'b1);
  end

  task automatic push(logic [10:0] v);
    push_en = 1;
    push_val = v;
    exp_q.push_back(v);
    @(negedge clk);
    push_en = 0;
  endtask

  task automatic cpu_read();
    int n = 0;
    cpu_req = 1;
    do @(negedge clk); while (!cpu_ack && ++n < 20);
    chk("cpu_to", cpu_ack, 1);
    cpu_req = 0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_cyc"}, rx_cyc, 0);
    chk({tag, "_ack"}, {cpu_ack, cpu_nodata}, 0);
    chk({tag, "_cdat"}, cpu_dat, 0);
    chk({tag, "_dval"}, dma_valid, 0);
    chk({tag, "_ddat"}, dma_dat, 0);
    chk({tag, "_irq"}, irq, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int r0, n, t, tp;
    logic prevg;
    logic [10:0] hold;
    idle(3);
    chk_zero("rst");
    rst = 1;
    idle(2);
    // Single CPU read of 0x41
    push(11'h041);
    idle(2);
    r0 = rdcnt;
    cpu_req = 1;
    @(negedge clk) chk("t1_read", rx_cyc, 1);
    @(negedge clk) chk("t1_gap", {rx_cyc, cpu_ack}, 0);
    @(negedge clk) chk("t1_ack", cpu_ack, 1);
    chk("t1_nodata", cpu_nodata, 0);
    chk("t1_dat", cpu_dat, 11'h041);
    cpu_req = 0;
    idle(4);
    chk("t1_reads", rdcnt - r0, 1);
    chk("t1_ack_off", cpu_ack, 0);
    // CPU read from empty FIFO
    r0 = rdcnt;
    cpu_req = 1;
    @(negedge clk) chk("t2_ack", cpu_ack, 1);
    chk("t2_nodata", cpu_nodata, 1);
    chk("t2_cyc", rx_cyc, 0);
    cpu_req = 0;
    idle(3);
    chk("t2_reads", rdcnt - r0, 0);
    // DMA burst on threshold
    dma_en = 1;
    dma_ready = 1;
    r0 = rdcnt;
    for (int i = 0; i < 8; i++) push({3'(i), 8'(8'h30 + i)});
    tp = 0;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do @(negedge clk); while (!(dma_valid && dma_ready) && ++n < 40);
      chk("t3_to", dma_valid && dma_ready, 1);
      t = cyc;
      if (i > 0) chk("t3_space", t - tp, 4);
      tp = t;
    end
    idle(8);
    chk("t3_done", dma_valid, 0);
    chk("t3_empty", rx_empty, 1);
    chk("t3_reads", rdcnt - r0, 8);
    dma_en = 0;
    // Idle timeout interrupt
    for (int i = 0; i < 3; i++) push(11'h0C0 + 11'(i));
    idle(2);
    chk("t4_irq_lo", irq, 0);
    n = 0;
    while (ticks < 640 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ticks", ticks, 640);
    chk("t4_irq_pre", irq, 0);
    @(negedge clk) chk("t4_irq", irq, 1);
    repeat (3) cpu_read();
    idle(3);
    chk("t4_irq_clr", irq, 0);
    // Alternation with a stalled DMA word
    prevg = gseq[$];
    gseq.delete();
    dma_ready = 0;
    for (int i = 0; i < 8; i++) push({3'(7 - i), 8'(8'h50 + 3 * i)});
    n = ndeliv;
    cpu_req = 1;
    dma_en = 1;
    t = 0;
    do @(negedge clk); while (!dma_valid && ++t < 20);
    chk("t5_stall_to", dma_valid, 1);
    hold = dma_dat;
    repeat (6) begin
      @(negedge clk);
      chk("t5_hold", dma_valid, 1);
      chk("t5_stable", dma_dat, hold);
      chk("t5_nocpu", cpu_ack, 0);
    end
    dma_ready = 1;
    t = 0;
    while (ndeliv - n < 8 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t5_to", ndeliv - n, 8);
    cpu_req = 0;
    dma_en = 0;
    idle(4);
    if (gseq.size() >= 8) begin
      chk("t5_first", gseq[0], !prevg);
      for (int i = 1; i < 8; i++) chk("t5_alt", gseq[i] != gseq[i-1], 1);
    end else chk("t5_gseq", gseq.size(), 8);
    // Reset during GAP loses the popped word only
    push(11'h7AA);
    push(11'h155);
    idle(1);
    cpu_req = 1;
    @(negedge clk) chk("t6_read", rx_cyc, 1);
    @(negedge clk) chk("t6_gap", {rx_cyc, cpu_ack}, 0);
    #2 rst = 0;
    #1 chk_zero("t6_rst");
    void'(exp_q.pop_front());
    @(negedge clk);
    cpu_req = 0;
    rst = 1;
    idle(2);
    cpu_read();
    chk("t6_dat", cpu_dat, 11'h155);
    idle(3);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart6551_rx_sched.md
# uart6551_rx_sched

Receive-side read scheduler for the 6551-style UART. Sits between the receiver's FIFO read port and two consumers: the CPU register path and a DMA stream. It shares the single read port between them, issues correctly spaced read cycles to the receiver, and starts DMA drains on a FIFO-level threshold or an idle timeout. When DMA is disabled, it raises an interrupt on the same conditions instead.

## Interface
Parameters:
- THRESH, 8: drain/irq level; condition is rx_qcnt >= THRESH; legal 1..15.
- TMO_TICKS, 640: baud16x ticks of idle-with-data before timeout (4 char times at 10-bit frames).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low.
- baud16x_ce  input  1  16x baud clock enable.
- rx_cyc / rx_cs / rx_wr  output  1 each  bus cycle to receiver; rx_wr always 0.
- rx_ack  input  1  receiver ack (combinational cyc&cs).
- rx_dout  input  8  FIFO head data.
- rx_break / rx_perr / rx_ferr  input  1 each  FIFO head status.
- rx_empty  input  1  receiver FIFO empty.
- rx_qcnt  input  4  receiver FIFO word count.
- cpu_req  input  1  level; CPU wants one word.
- cpu_ack  output  1  one-cycle pulse; cpu_dat valid.
- cpu_dat  output  11  {break, perr, ferr, data[7:0]}.
- cpu_nodata  output  1  valid with cpu_ack; 1 = FIFO was empty and no read was issued.
- dma_en  input  1  enable DMA draining.
- dma_valid  output  1  DMA word valid.
- dma_ready  input  1  DMA sink accepts.
- dma_dat  output  11  same format as cpu_dat.
- irq  output  1  level interrupt.

## Operation
- The receiver presents the FIFO head on rx_dout. It pops on the rising edge of ack&~wr; the pop takes effect at the end of that cycle.
- States:
  - IDLE: arbitrate.
  - READ: rx_cyc=rx_cs=1 for exactly one cycle; the captured word is registered from rx_dout/flags at the closing edge (pre-pop value).
  - GAP: rx_cyc=0 for one cycle, so the next read forms a new edge and rx_empty/rx_qcnt settle.
  - DELIVER: present the word.
- Burst flag:
  - Set in IDLE when dma_en & (rx_qcnt >= THRESH | tmo).
  - Cleared in GAP when rx_empty=1, and cleared immediately when dma_en=0.
- Arbitration in IDLE:
  - If cpu_req and rx_empty, issue cpu_ack with cpu_nodata=1; no read.
  - If cpu_req and burst are both pending, the CPU wins unless the last grant was the CPU; strict alternation.
  - Otherwise grant whichever requester is pending.
  - last_grant resets to DMA.
- DELIVER for CPU: cpu_ack=1 for one cycle, then IDLE.
- DELIVER for DMA: dma_valid=1 and dma_dat held stable until dma_ready. On acceptance, go to IDLE; the next burst word is re-arbitrated there.
- Timeout counter:
  - Counts baud16x_ce while rx_empty=0 and state=IDLE.
  - Clears on any READ or on rx_empty=1.
  - Saturates at TMO_TICKS and sets tmo; tmo clears with the counter.
- irq = ~dma_en & (rx_qcnt >= THRESH | tmo), registered.
- Arithmetic: the counter width is clog2(TMO_TICKS+1) and it never wraps. The comparison against rx_qcnt is 4-bit unsigned.

## Timing
- Reset values: rx_cyc=rx_cs=rx_wr=0, cpu_ack=0, cpu_nodata=0, cpu_dat=0, dma_valid=0, dma_dat=0, irq=0, state=IDLE, burst=0, tmo=0, counter=0.
- CPU read, FIFO non-empty: cpu_req sampled in IDLE at cycle 0, READ in cycle 1, GAP in cycle 2, cpu_ack in cycle 3.
- CPU read, FIFO empty: cpu_ack and cpu_nodata in cycle 1.
- The CPU must drop cpu_req in the cycle after cpu_ack, or it is treated as a new request.
- Minimum spacing between READ cycles is 3 clocks, so every read is a distinct rising edge.
- dma_ready held high gives one DMA word per 4 clocks. dma_valid never drops without acceptance.
- Reset mid-operation: return to IDLE immediately. A word captured in READ/GAP/DELIVER is lost because it has already been popped; this is accepted behaviour.
- dma_en falling during DELIVER(DMA): the word is still held until dma_ready; only the burst ends.

## Structure
- Package uart6551_pkg:
  - state enum {IDLE, READ, GAP, DELIVER}.
  - grant enum {G_CPU, G_DMA}.
  - rx_word_t packed struct {brk, perr, ferr, data[7:0]}.
- Sub-module uart6551_rx_tmo: timeout counter (baud16x_ce, rx_empty, clr, tmo). Everything else stays in the top module.

## Test plan
- FIFO holds 0x41, cpu_req pulse -> rx_cyc high in exactly one cycle; cpu_ack 3 cycles after request with cpu_dat=0x041 and cpu_nodata=0; rx_cyc low again before any further read.
- Empty FIFO, cpu_req -> cpu_ack in the next cycle with cpu_nodata=1; rx_cyc never asserted.
- dma_en=1, THRESH=8, receiver fills to qcnt=8, dma_ready=1 -> 8 dma_valid words in order, each 4 clocks apart; burst ends on empty.
- dma_en=0, 3 bytes received, then idle for 640 baud ticks -> irq rises on tick 640; a CPU read of all 3 words clears tmo and irq.
- Burst active with cpu_req held -> grants alternate CPU, DMA, CPU, ...; dma_ready=0 stalls dma_valid with dma_dat stable, and CPU reads proceed only after that word is accepted.
- rst asserted during GAP -> all outputs 0 asynchronously; after release, state=IDLE and the next read returns the following FIFO word.
